ervp_memory_cell_mr1wc: RTL and testbench

ERVP_MEMORY_CELL_MR1WC -- requirements
Module: ervp_memory_cell_mr1wc

---
 rtl/ervp_memory_cell_mr1wc_pkg.sv | 27 ++
 rtl/ervp_memory_cell_rport.sv | 78 +++++++
 rtl/ervp_memory_cell_mr1wc.sv | 100 ++++++++++
 tb/tb_ervp_memory_cell_mr1wc.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ervp_memory_cell_mr1wc_pkg.sv
// Shared elaboration helpers for the multi-read, single-write memory cell.
// Index sizing, subword counting and read-latency legality live here so every file agrees.
package ervp_memory_cell_mr1wc_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic int log2ru(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int divideru(input int dividend, input int divisor);
        return (dividend + divisor - 1) / divisor;
    endfunction

    function automatic bit rd_latency_ok(input int latency);
        return (latency >= RD_LATENCY_MIN) && (latency <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/ervp_memory_cell_rport.sv
// One read port: write-first forwarding, optional combinational bypass and the
// 1- or 2-stage registered read pipeline with its valid pulse.
module ervp_memory_cell_rport
    import ervp_memory_cell_mr1wc_pkg::*;
#(
    parameter int WIDTH             = 32,
    parameter int BW_INDEX          = 4,
    parameter int RD_LATENCY        = 1,
    parameter int USE_ASYNCH_BYPASS = 0
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic [BW_INDEX-1:0] windex,
    input  logic [WIDTH-1:0]    wmask,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [BW_INDEX-1:0] rindex,
    input  logic [WIDTH-1:0]    stored,
    input  logic                renable,
    output logic [WIDTH-1:0]    rdata_asynch,
    output logic [WIDTH-1:0]    rdata_synch,
    output logic                rvalid
);

    logic [WIDTH-1:0] hit_mask;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("ervp_memory_cell_rport: RD_LATENCY must be 1 or 2");
    end

    // wmask is already zero for out-of-range or reset-blocked writes
    assign hit_mask = (windex == rindex) ? wmask : '0;
    assign merged   = (stored & ~hit_mask) | (wdata & hit_mask);

    if (USE_ASYNCH_BYPASS != 0) begin : g_bypass
        assign rdata_asynch = merged;
    end else begin : g_no_bypass
        assign rdata_asynch = stored;
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= renable;
            if (renable) begin
                s1_data <= merged;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [WIDTH-1:0] s2_data;
        logic             s2_valid;

        always_ff @(posedge clk) begin
            if (!rstnn) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rdata_synch = s2_data;
        assign rvalid      = s2_valid;
    end else begin : g_lat1
        assign rdata_synch = s1_data;
        assign rvalid      = s1_valid;
    end

endmodule

// File: rtl/ervp_memory_cell_mr1wc.sv
// Register-array memory with one masked write port and NUM_RPORT independent
// read ports, each offering a combinational and a pipelined synchronous view.
module ervp_memory_cell_mr1wc
    import ervp_memory_cell_mr1wc_pkg::*;
#(
    parameter int DEPTH              = 16,
    parameter int WIDTH              = 32,
    parameter int BW_INDEX           = 4,
    parameter int NUM_RPORT          = 2,
    parameter int USE_SUBWORD_ENABLE = 0,
    parameter int BW_SUBWORD         = 8,
    parameter int RD_LATENCY         = 1,
    parameter int RESET_CONTENT      = 0,
    parameter int USE_ASYNCH_BYPASS  = 0,
    localparam int BW_SELECT = (USE_SUBWORD_ENABLE != 0) ? divideru(WIDTH, BW_SUBWORD) : 1
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic [BW_INDEX-1:0]           windex,
    input  logic                          wenable,
    input  logic [BW_SELECT-1:0]          wpermit,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [NUM_RPORT*BW_INDEX-1:0] rindex,
    input  logic [NUM_RPORT-1:0]          renable,
    output logic [NUM_RPORT*WIDTH-1:0]    rdata_asynch,
    output logic [NUM_RPORT*WIDTH-1:0]    rdata_synch,
    output logic [NUM_RPORT-1:0]          rvalid
);

    localparam logic [BW_INDEX:0] DEPTH_LIMIT = (BW_INDEX + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] permit_bits;
    logic [WIDTH-1:0] wmask;
    logic             windex_ok;

    if (BW_INDEX < log2ru(DEPTH)) begin : g_bad_index
        $error("ervp_memory_cell_mr1wc: BW_INDEX too narrow for DEPTH");
    end
    if ((NUM_RPORT < 1) || (NUM_RPORT > 8)) begin : g_bad_rport
        $error("ervp_memory_cell_mr1wc: NUM_RPORT must be 1..8");
    end

    if (USE_SUBWORD_ENABLE != 0) begin : g_subword
        always_comb begin
            permit_bits = '0;
            for (int i = 0; i < WIDTH; i++) begin
                permit_bits[i] = wpermit[i / BW_SUBWORD];
            end
        end
    end else begin : g_fullword
        logic unused_wpermit;
        assign unused_wpermit = &{1'b0, wpermit};
        assign permit_bits    = '1;
    end

    assign windex_ok = ({1'b0, windex} < DEPTH_LIMIT);
    // Writes are suppressed during reset; the same mask drives forwarding
    assign wmask = (rstnn && wenable && windex_ok) ? permit_bits : '0;

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            if (RESET_CONTENT != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (|wmask) begin
            mem[windex] <= (mem[windex] & ~wmask) | (wdata & wmask);
        end
    end

    for (genvar p = 0; p < NUM_RPORT; p++) begin : g_rport
        logic [BW_INDEX-1:0] port_index;
        logic [WIDTH-1:0]    port_stored;

        assign port_index  = rindex[p*BW_INDEX +: BW_INDEX];
        assign port_stored = ({1'b0, port_index} < DEPTH_LIMIT) ? mem[port_index] : '0;

        ervp_memory_cell_rport #(
            .WIDTH             (WIDTH),
            .BW_INDEX          (BW_INDEX),
            .RD_LATENCY        (RD_LATENCY),
            .USE_ASYNCH_BYPASS (USE_ASYNCH_BYPASS)
        ) u_rport (
            .clk          (clk),
            .rstnn        (rstnn),
            .windex       (windex),
            .wmask        (wmask),
            .wdata        (wdata),
            .rindex       (port_index),
            .stored       (port_stored),
            .renable      (renable[p]),
            .rdata_asynch (rdata_asynch[p*WIDTH +: WIDTH]),
            .rdata_synch  (rdata_synch[p*WIDTH +: WIDTH]),
            .rvalid       (rvalid[p])
        );
    end

endmodule

// File: tb/tb_ervp_memory_cell_mr1wc.sv
// Drives a default instance and a DEPTH=12 / subword / latency-2 / clearing /
// bypass instance with shared stimulus, checking both against a word-array model.
module tb_ervp_memory_cell_mr1wc;

    logic        clk;
    logic        rstnn;
    logic [3:0]  windex;
    logic        wenable;
    logic [3:0]  wpermit;
    logic [31:0] wdata;
    logic [7:0]  rindex;
    logic [1:0]  renable;
    logic [63:0] ra_asynch, ra_synch, rb_asynch, rb_synch;
    logic [1:0]  ra_valid, rb_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-instance configuration: index 0 = default, index 1 = variant
    int depth_of  [2] = '{16, 12};
    int lat_of    [2] = '{1, 2};
    int sub_of    [2] = '{0, 1};
    int byp_of    [2] = '{0, 1};
    int clr_of    [2] = '{0, 1};

    logic [31:0] m_mem     [2][16];
    bit          m_known   [2][16];
    logic [31:0] exp_data  [2][2];
    logic        exp_valid [2][2];
    logic [31:0] sch_data  [2][2][4];
    bit          sch_valid [2][2][4];
    int          edge_n = 0;

    ervp_memory_cell_mr1wc dut_a (
        .clk          (clk),
        .rstnn        (rstnn),
        .windex       (windex),
        .wenable      (wenable),
        .wpermit      (wpermit[0]),
        .wdata        (wdata),
        .rindex       (rindex),
        .renable      (renable),
        .rdata_asynch (ra_asynch),
        .rdata_synch  (ra_synch),
        .rvalid       (ra_valid)
    );

    ervp_memory_cell_mr1wc #(
        .DEPTH              (12),
        .USE_SUBWORD_ENABLE (1),
        .RD_LATENCY         (2),
        .RESET_CONTENT      (1),
        .USE_ASYNCH_BYPASS  (1)
    ) dut_b (
        .clk          (clk),
        .rstnn        (rstnn),
        .windex       (windex),
        .wenable      (wenable),
        .wpermit      (wpermit),
        .wdata        (wdata),
        .rindex       (rindex),
        .renable      (renable),
        .rdata_asynch (rb_asynch),
        .rdata_synch  (rb_synch),
        .rvalid       (rb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] obs_asynch(int d, int p);
        return (d == 0) ? ra_asynch[p*32 +: 32] : rb_asynch[p*32 +: 32];
    endfunction

    function automatic logic [31:0] obs_synch(int d, int p);
        return (d == 0) ? ra_synch[p*32 +: 32] : rb_synch[p*32 +: 32];
    endfunction

    function automatic logic obs_valid(int d, int p);
        return (d == 0) ? ra_valid[p] : rb_valid[p];
    endfunction

    // Bits the current write would actually change in instance d
    function automatic logic [31:0] wr_mask(int d);
        logic [31:0] m;
        m = '0;
        if (rstnn && wenable && (int'(windex) < depth_of[d])) begin
            for (int b = 0; b < 4; b++) begin
                if (sub_of[d] == 0 || wpermit[b]) m[b*8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] stored_word(int d, int idx);
        return (idx < depth_of[d]) ? m_mem[d][idx] : 32'h0;
    endfunction

    function automatic bit word_known(int d, int idx);
        return (idx >= depth_of[d]) || m_known[d][idx];
    endfunction

    function automatic logic [31:0] fwd_word(int d, int idx);
        logic [31:0] msk;
        msk = (int'(windex) == idx) ? wr_mask(d) : 32'h0;
        return (stored_word(d, idx) & ~msk) | (wdata & msk);
    endfunction

    // One clock: check combinational reads before the edge, advance the model, check registered reads after
    task automatic step();
        logic [31:0] cap  [2][2];
        bit          capv [2][2];
        logic [31:0] wm   [2];
        int          widx;
        logic [31:0] wd;
        bit          rst_now;
        int          idx;
        int          slot;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            wm[d] = wr_mask(d);
            for (int p = 0; p < 2; p++) begin
                idx = int'(rindex[p*4 +: 4]);
                if (word_known(d, idx))
                    chk($sformatf("asynch d%0d p%0d idx%0d", d, p, idx), obs_asynch(d, p),
                        (byp_of[d] != 0) ? fwd_word(d, idx) : stored_word(d, idx));
                capv[d][p] = renable[p];
                cap[d][p]  = fwd_word(d, idx);
            end
        end
        widx    = int'(windex);
        wd      = wdata;
        rst_now = !rstnn;
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            if (rst_now) begin
                if (clr_of[d] != 0) begin
                    for (int i = 0; i < 16; i++) begin
                        m_mem[d][i]   = '0;
                        m_known[d][i] = 1'b1;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    exp_data[d][p]  = '0;
                    exp_valid[d][p] = 1'b0;
                    for (int s = 0; s < 4; s++) sch_valid[d][p][s] = 1'b0;
                end
            end else begin
                if (wm[d] != 0) begin
                    m_mem[d][widx] = (m_mem[d][widx] & ~wm[d]) | (wd & wm[d]);
                    if (wm[d] == 32'hFFFF_FFFF) m_known[d][widx] = 1'b1;
                end
                for (int p = 0; p < 2; p++) begin
                    if (capv[d][p]) begin
                        slot = (edge_n + lat_of[d] - 1) % 4;
                        sch_valid[d][p][slot] = 1'b1;
                        sch_data[d][p][slot]  = cap[d][p];
                    end
                    slot = edge_n % 4;
                    exp_valid[d][p] = sch_valid[d][p][slot];
                    if (sch_valid[d][p][slot]) exp_data[d][p] = sch_data[d][p][slot];
                    sch_valid[d][p][slot] = 1'b0;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("synch d%0d p%0d e%0d", d, p, edge_n), obs_synch(d, p), exp_data[d][p]);
                chk($sformatf("rvalid d%0d p%0d e%0d", d, p, edge_n), 32'(obs_valid(d, p)), 32'(exp_valid[d][p]));
            end
        end
    endtask

    task automatic idle();
        wenable = 1'b0;
        renable = 2'b00;
        wpermit = 4'hF;
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        wenable = 1'b1;
        windex  = 4'(idx);
        wdata   = data;
        wpermit = 4'hF;
    endtask

    task automatic rd(input int idx0, input int idx1);
        renable = 2'b11;
        rindex  = {4'(idx1), 4'(idx0)};
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[d][i]   = 'x;
                m_known[d][i] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                exp_data[d][p]  = '0;
                exp_valid[d][p] = 1'b0;
                for (int s = 0; s < 4; s++) sch_valid[d][p][s] = 1'b0;
            end
        end
        rstnn  = 1'b0;
        windex = '0;
        wdata  = '0;
        rindex = '0;
        idle();
        repeat (3) step();
        rstnn = 1'b1;

        // Fill every index, then read it all back on both ports
        for (int k = 0; k < 16; k++) begin
            wr(k, 32'hA500_0000 + 32'(k));
            step();
        end
        idle();
        for (int k = 0; k < 16; k++) begin
            rd(k, 15 - k);
            step();
        end
        idle();
        repeat (2) step();

        // Subword write colliding with reads of the same index on both ports
        wr(3, 32'h1122_3344);
        step();
        wdata   = 32'hAABB_CCDD;
        wpermit = 4'b0101;
        rd(3, 3);
        step();
        chk("collision full-word p0", ra_synch[31:0], 32'hAABB_CCDD);
        chk("collision full-word p1", ra_synch[63:32], 32'hAABB_CCDD);
        idle();
        step();
        chk("collision subword p0", rb_synch[31:0], 32'h11BB_33DD);
        chk("collision subword p1", rb_synch[63:32], 32'h11BB_33DD);

        // Latency-2 capture is immune to a write in the following cycle
        wr(5, 32'h5);
        step();
        wenable = 1'b0;
        renable = 2'b01;
        rindex  = {4'd0, 4'd5};
        step();
        renable = 2'b00;
        wr(5, 32'h9);
        step();
        chk("lat2 data", rb_synch[31:0], 32'h5);
        chk("lat2 rvalid", 32'(rb_valid), 32'h1);
        idle();
        step();

        // Out-of-range write then read of index 14
        wr(14, 32'hFFFF_FFFF);
        step();
        wenable = 1'b0;
        rd(14, 14);
        step();
        idle();
        step();
        chk("out-of-range read", rb_synch[31:0], 32'h0);
        for (int k = 0; k < 12; k++) begin
            rd(k, 11 - k);
            step();
        end
        idle();
        repeat (2) step();

        // Hold: registered data and rvalid stay put while the word is rewritten
        wr(7, 32'h0000_CAFE);
        step();
        wenable = 1'b0;
        rd(7, 7);
        step();
        idle();
        step();
        for (int i = 0; i < 10; i++) begin
            wr(7, $urandom);
            step();
        end
        chk("hold a", ra_synch[31:0], 32'h0000_CAFE);
        chk("hold b", rb_synch[63:32], 32'h0000_CAFE);
        idle();

        // Reset arriving while a latency-2 read is in flight
        rd(1, 2);
        step();
        renable = 2'b00;
        rstnn   = 1'b0;
        repeat (2) step();
        rstnn = 1'b1;
        repeat (2) step();
        chk("reset drop rvalid", 32'(rb_valid), 32'h0);
        chk("reset drop data", rb_synch[31:0], 32'h0);
        for (int k = 0; k < 16; k++) begin
            rd(k, 15 - k);
            step();
        end
        idle();
        repeat (2) step();

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            rstnn   = ($urandom_range(0, 39) != 0);
            wenable = $urandom_range(0, 1) != 0;
            windex  = 4'($urandom_range(0, 15));
            wpermit = 4'($urandom);
            wdata   = $urandom;
            renable = 2'($urandom);
            rindex  = 8'($urandom);
            step();
        end
        rstnn = 1'b1;
        idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
